// File: rtl/adc_to_fp_converter_if.sv
// rtl/adc_to_fp_converter_if.sv - sample-in / float-out handshake bundle for adc_to_fp_converter
//
// Signals:
//   in_valid  : producer -> converter, sample on in_data is valid
//   in_ready  : converter -> producer, converter can accept a sample
//   in_data   : producer -> converter, raw ADC sample (ADC_W bits)
//   out_valid : converter -> consumer, out_data holds a converted float
//   out_ready : consumer -> converter, consumer accepts out_data
//   out_data  : converter -> consumer, IEEE-754 single {sign, exp[7:0], mant[22:0]}
// Modports: master = the side driving samples and taking floats; slave = the converter.

interface adc_to_fp_converter_if #(
    parameter int XLEN  = 32,
    parameter int ADC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [ADC_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/adc_to_fp_converter.sv
// rtl/adc_to_fp_converter.sv - iterative ADC sample to IEEE-754 single converter
//
// Purpose: accepts one ADC sample, normalises it one bit per cycle and presents
// the exact single-precision value until the consumer takes it.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : adc_to_fp_converter_if.slave (in_valid/in_ready/in_data,
//         out_valid/out_ready/out_data)
// Parameters: XLEN (32 only), ADC_W (2..24).
// Build option: define ADC_SIGNED_EN to treat in_data as two's complement.

module adc_to_fp_converter #(
    parameter int XLEN  = 32,
    parameter int ADC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_to_fp_converter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_e;

    // Exponent of a sample whose leading one is already in the top bit.
    localparam logic [7:0] EXP_INIT = 8'(127 + ADC_W - 1);

    state_e           state_q, state_d;
    logic [ADC_W-1:0] mag_q, mag_d;
    logic [7:0]       exp_q, exp_d;
    logic [XLEN-1:0]  out_data_q, out_data_d;
    logic             sign_q, sign_d;

    logic [ADC_W-1:0] in_mag;
    logic             in_sign;
    logic [22:0]      mant;

    // Magnitude/sign of the incoming sample.
`ifdef ADC_SIGNED_EN
    // Negating the most negative code wraps to 2^(ADC_W-1), which read as
    // unsigned is exactly the required magnitude.
    assign in_sign = bus.in_data[ADC_W-1];
    assign in_mag  = in_sign ? (~bus.in_data + ADC_W'(1)) : bus.in_data;
`else
    assign in_sign = 1'b0;
    assign in_mag  = bus.in_data;
`endif

    // Bits below the leading one, left-aligned and zero-padded.
    always_comb begin
        mant = '0;
        mant[22 -: (ADC_W-1)] = mag_q[ADC_W-2:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = (in_mag == '0) ? DONE : NORM;
                end
            end
            NORM: begin
                if (mag_q[ADC_W-1]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    // Datapath next-state
    always_comb begin
        mag_d      = mag_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mag_d  = in_mag;
                    exp_d  = EXP_INIT;
                    sign_d = in_sign;
                    if (in_mag == '0) begin
                        out_data_d = '0;
                    end
                end
            end
            NORM: begin
                if (!mag_q[ADC_W-1]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'd1;
                end else begin
                    out_data_d = XLEN'({sign_q, exp_q, mant});
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q      <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            mag_q      <= mag_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_adc_to_fp_converter.sv
// tb/tb_adc_to_fp_converter.sv - self-checking bench for adc_to_fp_converter

module tb_adc_to_fp_converter;

    localparam int XLEN  = 32;
    localparam int ADC_W = 16;

    typedef struct {
        logic [15:0] din;
        logic [31:0] dout;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adc_to_fp_converter_if #(.XLEN(XLEN), .ADC_W(ADC_W)) bus ();

    adc_to_fp_converter #(.XLEN(XLEN), .ADC_W(ADC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Wait for out_valid (sampled #1 after an edge); k counts edges since acceptance.
    task automatic wait_output(output int k);
        k = 1;
        while (!bus.out_valid && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic collect(input int k);
        exp_t e;
        if (!bus.out_valid) begin
            check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        end else if (sb.size() == 0) begin
            check("unexpected_output", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("out_data", bus.out_data, e.dout);
            check("latency", 32'(k), 32'(e.lat));
        end
    endtask

    // Drive one sample, push its expectation, accept at the next edge.
    task automatic accept(input logic [15:0] din, input logic [31:0] dout, input int lat);
        exp_t e;
        @(negedge clk);
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        e.dout = dout;
        e.lat  = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic watch_no_output(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    logic [15:0] bp_din;
    logic [31:0] bp_dout;
    int          k;
    int          acc;
    int          outs;

    initial begin
`ifdef ADC_SIGNED_EN
        vecs.push_back('{16'hFFFF, 32'hBF800000, 17});
        vecs.push_back('{16'h8000, 32'hC7000000,  2});
        vecs.push_back('{16'h0000, 32'h00000000,  1});
        vecs.push_back('{16'h0002, 32'h40000000, 16});
        vecs.push_back('{16'h7FFF, 32'h46FFFE00,  3});
        vecs.push_back('{16'hFFFE, 32'hC0000000, 16});
        vecs.push_back('{16'h0001, 32'h3F800000, 17});
        bp_din  = 16'h8000;
        bp_dout = 32'hC7000000;
`else
        vecs.push_back('{16'h0001, 32'h3F800000, 17});
        vecs.push_back('{16'hFFFF, 32'h477FFF00,  2});
        vecs.push_back('{16'h0000, 32'h00000000,  1});
        vecs.push_back('{16'h0002, 32'h40000000, 16});
        vecs.push_back('{16'h8000, 32'h47000000,  2});
        vecs.push_back('{16'h00FF, 32'h437F0000, 10});
        vecs.push_back('{16'h1234, 32'h4591A000,  5});
        vecs.push_back('{16'h7FFF, 32'h46FFFE00,  3});
        bp_din  = 16'hFFFF;
        bp_dout = 32'h477FFF00;
`endif

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", bus.out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven conversions with out_ready held high.
        for (int i = 0; i < vecs.size(); i++) begin
            accept(vecs[i].din, vecs[i].dout, vecs[i].lat);
            wait_output(k);
            collect(k);
            @(posedge clk); #1;
            check("return_idle_out_valid", 32'(bus.out_valid), 32'd0);
            check("return_idle_in_ready", 32'(bus.in_ready), 32'd1);
        end

        // Backpressure: hold DONE for 10 cycles, inject an ignored sample.
        @(negedge clk);
        bus.out_ready = 1'b0;
        accept(bp_din, bp_dout, 2);
        wait_output(k);
        collect(k);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_data", bus.out_data, bp_dout);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = (i == 3);
            bus.in_data  = 16'h0001;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        watch_no_output("bp_ignored_sample", 25);

        // Reset in the middle of normalising 0x0001.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mid_norm_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_norm_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_norm_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_norm_out_data", bus.out_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        watch_no_output("rst_norm_no_output", 30);

        // Reset wins over a simultaneous in_valid.
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        @(posedge clk); #1;
        check("rst_prio_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        watch_no_output("rst_prio_no_output", 25);
        check("rst_prio_idle", 32'(bus.in_ready), 32'd1);

        // Back-to-back throughput: 0x4000 (one leading zero) every 4 cycles.
        acc  = 0;
        outs = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h4000;
        for (int i = 0; i < 30; i++) begin
            if (bus.in_ready) acc++;
            if (bus.out_valid) begin
                outs++;
                check("b2b_out_data", bus.out_data, 32'h46800000);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd8);
        check("b2b_outputs", 32'(outs), 32'd7);
        repeat (10) @(posedge clk);
        #1;
        check("b2b_drained_in_ready", 32'(bus.in_ready), 32'd1);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
